// File: rtl/pin_verifier_pkg.sv
// Shared definitions for the PIN verification session controller:
// FSM state encodings, failure codes and Authenticator status values.
package pin_verifier_pkg;

   // Session controller states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CHECK_ACC = 3'd1,
      ST_WAIT_PIN  = 3'd2,
      ST_COMPARE   = 3'd3,
      ST_GRANTED   = 3'd4,
      ST_FAIL      = 3'd5
   } state_t;

   // Reason reported on fail_code alongside auth_fail
   localparam logic [1:0] FAIL_NO_ACC  = 2'd0;
   localparam logic [1:0] FAIL_TIMEOUT = 2'd1;
   localparam logic [1:0] FAIL_LOCKED  = 2'd2;
   localparam logic [1:0] FAIL_CANCEL  = 2'd3;

   // Authenticator lookup status on acc_found_stat
   localparam logic ACCOUNT_FOUND     = 1'b1;
   localparam logic ACCOUNT_NOT_FOUND = 1'b0;

endpackage

// File: rtl/pin_verifier_pin_table.sv
// Combinational PIN ROM: account index -> stored PIN.
// PINs are stored as plain binary integers (decimal 1234 etc.).
// Indices outside the table return all ones, which no session can reach
// because out-of-range accounts are rejected before PIN comparison.
module pin_table #(
   parameter int NUM_ACCOUNTS = 10,
   parameter int PIN_W        = 16,
   parameter int IDX_W        = 4
) (
   input  logic [IDX_W-1:0] idx,
   output logic [PIN_W-1:0] pin
);

   // ROM lookup with all-ones default for unmapped indices
   always_comb begin
      pin = '1;
      case (idx)
         IDX_W'(0): pin = PIN_W'(1234);
         IDX_W'(1): pin = PIN_W'(2345);
         IDX_W'(2): pin = PIN_W'(3456);
         IDX_W'(3): pin = PIN_W'(4567);
         IDX_W'(4): pin = PIN_W'(5678);
         IDX_W'(5): pin = PIN_W'(6789);
         IDX_W'(6): pin = PIN_W'(7890);
         IDX_W'(7): pin = PIN_W'(8901);
         IDX_W'(8): pin = PIN_W'(9012);
         IDX_W'(9): pin = PIN_W'(7123);
         default:   pin = '1;
      endcase
      if (32'(idx) >= NUM_ACCOUNTS) pin = '1;
   end

endmodule

// File: rtl/pin_verifier.sv
// Login session controller. Latches the account reported by the
// Authenticator, collects PIN attempts, compares them against the PIN ROM,
// counts down remaining tries, locks accounts on exhaustion and times out
// idle PIN entry.
//
// Input strobes: start, pin_valid, logout, cancel and unlock_req are
// single-cycle level-sampled requests with no ready/backpressure; each is
// acted on at the rising edge where it is high, and only in the states that
// consume it (start in IDLE, pin_valid/cancel in WAIT_PIN, logout/cancel in
// GRANTED, unlock_req everywhere). Requests in other states are dropped.
//
// state_dbg exposes the current FSM state for observation.
module pin_verifier
   import pin_verifier_pkg::*;
#(
   parameter int NUM_ACCOUNTS   = 10,
   parameter int MAX_TRIES      = 3,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int PIN_W          = 16,
   parameter int IDX_W          = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             acc_found_stat,
   input  logic [IDX_W-1:0] acc_index_in,
   input  logic [PIN_W-1:0] pin_in,
   input  logic             pin_valid,
   input  logic             cancel,
   input  logic             logout,
   input  logic             unlock_req,
   input  logic [IDX_W-1:0] unlock_index,
   output logic             session_active,
   output logic [IDX_W-1:0] acc_index,
   output logic             auth_ok,
   output logic             auth_fail,
   output logic [1:0]       fail_code,
   output logic [2:0]       attempts_left,
   output logic             busy,
   output state_t           state_dbg
);

   localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q;
   logic                    found_q;
   logic [PIN_W-1:0]        pin_q;
   logic [2:0]              attempts_q;
   logic [TMR_W-1:0]        timer_q;
   logic [1:0]              fail_code_q, fail_code_d;
   logic                    auth_ok_q;
   logic [NUM_ACCOUNTS-1:0] lock_q;

   logic                    load_acc;
   logic                    load_pin;
   logic                    init_tries;
   logic                    dec_tries;
   logic                    set_lock;
   logic                    timer_clr;
   logic                    timer_inc;
   logic                    grant;

   logic [PIN_W-1:0]        table_pin;
   logic                    acc_ok;
   logic                    acc_locked;
   logic                    pin_match;

   pin_table #(
      .NUM_ACCOUNTS (NUM_ACCOUNTS),
      .PIN_W        (PIN_W),
      .IDX_W        (IDX_W)
   ) u_pin_table (
      .idx (idx_q),
      .pin (table_pin)
   );

   // A found account with an index outside the table is treated as unknown
   assign acc_ok    = (found_q == ACCOUNT_FOUND) && (32'(idx_q) < NUM_ACCOUNTS);
   assign pin_match = (pin_q == table_pin);

   // Lock bit of the latched account
   always_comb begin
      acc_locked = 1'b0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
         if (idx_q == IDX_W'(i)) acc_locked = lock_q[i];
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and datapath control decode
   always_comb begin
      state_d     = state_q;
      load_acc    = 1'b0;
      load_pin    = 1'b0;
      init_tries  = 1'b0;
      dec_tries   = 1'b0;
      set_lock    = 1'b0;
      timer_clr   = 1'b0;
      timer_inc   = 1'b0;
      grant       = 1'b0;
      fail_code_d = fail_code_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               load_acc = 1'b1;
               state_d  = ST_CHECK_ACC;
            end
         end
         ST_CHECK_ACC: begin
            if (!acc_ok) begin
               fail_code_d = FAIL_NO_ACC;
               state_d     = ST_FAIL;
            end else if (acc_locked) begin
               fail_code_d = FAIL_LOCKED;
               state_d     = ST_FAIL;
            end else begin
               init_tries = 1'b1;
               timer_clr  = 1'b1;
               state_d    = ST_WAIT_PIN;
            end
         end
         ST_WAIT_PIN: begin
            if (cancel) begin
               fail_code_d = FAIL_CANCEL;
               state_d     = ST_FAIL;
            end else if (pin_valid) begin
               load_pin  = 1'b1;
               timer_clr = 1'b1;
               state_d   = ST_COMPARE;
            end else if (timer_q == TMR_LAST) begin
               fail_code_d = FAIL_TIMEOUT;
               state_d     = ST_FAIL;
            end else begin
               timer_inc = 1'b1;
            end
         end
         ST_COMPARE: begin
            if (pin_match) begin
               grant   = 1'b1;
               state_d = ST_GRANTED;
            end else begin
               dec_tries = 1'b1;
               if (attempts_q == 3'd1) begin
                  set_lock    = 1'b1;
                  fail_code_d = FAIL_LOCKED;
                  state_d     = ST_FAIL;
               end else begin
                  timer_clr = 1'b1;
                  state_d   = ST_WAIT_PIN;
               end
            end
         end
         ST_GRANTED: begin
            if (logout || cancel) state_d = ST_IDLE;
         end
         ST_FAIL: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Session datapath: latched account, PIN, try counter, timer, result flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         found_q     <= ACCOUNT_NOT_FOUND;
         pin_q       <= '0;
         attempts_q  <= '0;
         timer_q     <= '0;
         fail_code_q <= FAIL_NO_ACC;
         auth_ok_q   <= 1'b0;
      end else begin
         if (load_acc) begin
            idx_q   <= acc_index_in;
            found_q <= acc_found_stat;
         end
         if (load_pin) pin_q <= pin_in;
         if (init_tries)     attempts_q <= 3'(MAX_TRIES);
         else if (dec_tries) attempts_q <= attempts_q - 3'd1;
         if (timer_clr)      timer_q <= '0;
         else if (timer_inc) timer_q <= timer_q + TMR_W'(1);
         fail_code_q <= fail_code_d;
         auth_ok_q   <= grant;
      end
   end

   // Lock vector: a lock and an unlock of the same account in one cycle keeps the lock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q <= '0;
      end else begin
         for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (set_lock && (idx_q == IDX_W'(i)))                 lock_q[i] <= 1'b1;
            else if (unlock_req && (unlock_index == IDX_W'(i)))  lock_q[i] <= 1'b0;
         end
      end
   end

   assign session_active = (state_q == ST_GRANTED);
   assign busy           = (state_q != ST_IDLE);
   assign auth_fail      = (state_q == ST_FAIL);
   assign auth_ok        = auth_ok_q;
   assign fail_code      = fail_code_q;
   assign acc_index      = idx_q;
   assign attempts_left  = attempts_q;
   assign state_dbg      = state_q;

endmodule
